// File: rtl/parking_pkg.sv
// Shared types and helpers for the parking occupancy controller.
// Optional water lockout is enabled with the WATER_LOCKOUT_EN macro (see top module).
package parking_pkg;

    typedef enum logic [1:0] {
        WAIT_LOW = 2'd0,
        IDLE     = 2'd1,
        ARMING   = 2'd2,
        HELD     = 2'd3
    } det_state_t;

    localparam int DEFAULT_CAPACITY = 40;
    localparam int DEFAULT_DEBOUNCE = 2;

    // popcount operates on a fixed-width vector; callers zero-extend into it.
    localparam int POP_MAX_W = 64;

    function automatic logic [7:0] popcount(input logic [POP_MAX_W-1:0] v);
        logic [7:0] n;
        n = '0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            n = n + {7'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/parking_occupancy_ctrl_gate_detector.sv
// gate_detector: debounces one car sensor and emits a single 1-cycle evt per car.
// A sensor that is already high when reset releases must go low before it can count.
module gate_detector
    import parking_pkg::*;
#(
    parameter int DEBOUNCE = DEFAULT_DEBOUNCE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sensor,
    output logic       evt,
    output logic [1:0] state_dbg
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] DEB = CW'(DEBOUNCE);
    localparam logic [CW-1:0] ONE = CW'(1);

    det_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          evt_q, evt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        evt_d   = 1'b0;
        case (state_q)
            WAIT_LOW: begin
                if (!sensor) state_d = IDLE;
            end
            IDLE: begin
                if (sensor) begin
                    cnt_d = ONE;
                    if (ONE == DEB) begin
                        state_d = HELD;
                        evt_d   = 1'b1;
                    end else begin
                        state_d = ARMING;
                    end
                end
            end
            ARMING: begin
                if (sensor) begin
                    cnt_d = cnt_q + ONE;
                    if (cnt_q + ONE == DEB) begin
                        state_d = HELD;
                        evt_d   = 1'b1;
                    end
                end else begin
                    // Short glitch: drop it without counting.
                    state_d = IDLE;
                end
            end
            HELD: begin
                if (!sensor) state_d = IDLE;
            end
            default: state_d = WAIT_LOW;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= WAIT_LOW;
            cnt_q   <= '0;
            evt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            evt_q   <= evt_d;
        end
    end

    assign evt       = evt_q;
    assign state_dbg = state_q;

endmodule

// File: rtl/parking_occupancy_ctrl.sv
// Multi-gate parking occupancy controller: per-sensor debounce plus a saturating counter.
// Define WATER_LOCKOUT_EN to close all entry barriers and refuse entries while flood is high.
module parking_occupancy_ctrl
    import parking_pkg::*;
#(
    parameter int N_GATES  = 2,
    parameter int CAPACITY = DEFAULT_CAPACITY,
    parameter int DEBOUNCE = DEFAULT_DEBOUNCE,
    localparam int CNT_W   = $clog2(CAPACITY + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_GATES-1:0]     ent_sensor,
    input  logic [N_GATES-1:0]     sai_sensor,
    input  logic                   flood,
    output logic [CNT_W-1:0]       occupancy,
    output logic                   vazio,
    output logic                   cheio,
    output logic [N_GATES-1:0]     ent_allowed,
    output logic                   rejected,
    output logic                   err_underflow,
    output logic [4*N_GATES-1:0]   det_state_dbg
);

    localparam int SUM_W = CNT_W + $clog2(N_GATES) + 1;
    localparam logic [SUM_W-1:0] CAP_S = SUM_W'(CAPACITY);
    localparam logic [SUM_W-1:0] ONE_S = SUM_W'(1);

    logic [N_GATES-1:0] ent_evt;
    logic [N_GATES-1:0] sai_evt;
    logic               lockout;

    for (genvar g = 0; g < N_GATES; g++) begin : g_det
        gate_detector #(.DEBOUNCE(DEBOUNCE)) u_ent (
            .clk       (clk),
            .reset     (reset),
            .sensor    (ent_sensor[g]),
            .evt       (ent_evt[g]),
            .state_dbg (det_state_dbg[2*g +: 2])
        );
        gate_detector #(.DEBOUNCE(DEBOUNCE)) u_sai (
            .clk       (clk),
            .reset     (reset),
            .sensor    (sai_sensor[g]),
            .evt       (sai_evt[g]),
            .state_dbg (det_state_dbg[2*(N_GATES+g) +: 2])
        );
    end

`ifdef WATER_LOCKOUT_EN
    assign lockout = flood;
`else
    logic unused_flood;
    assign unused_flood = flood;
    assign lockout      = 1'b0;
`endif

    logic [CNT_W-1:0]     occupancy_q, occupancy_d;
    logic                 rejected_q, rejected_d;
    logic                 err_underflow_q, err_underflow_d;
    logic [POP_MAX_W-1:0] exit_vec;
    logic [SUM_W-1:0]     n_exit, occ_ext, after_exit, space, granted;

    always_comb begin
        exit_vec                = '0;
        exit_vec[N_GATES-1:0]   = sai_evt;
        n_exit                  = SUM_W'(popcount(exit_vec));
        occ_ext                 = SUM_W'(occupancy_q);

        // Exits first, clamped at zero; any excess is flagged.
        err_underflow_d = (n_exit > occ_ext);
        after_exit      = err_underflow_d ? '0 : (occ_ext - n_exit);
        space           = CAP_S - after_exit;

        // Walking gates upward grants the remaining space to the lowest indices.
        granted    = '0;
        rejected_d = 1'b0;
        for (int g = 0; g < N_GATES; g++) begin
            if (ent_evt[g]) begin
                if (!lockout && (granted < space)) begin
                    granted = granted + ONE_S;
                end else begin
                    rejected_d = 1'b1;
                end
            end
        end

        occupancy_d = CNT_W'(after_exit + granted);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            occupancy_q     <= '0;
            rejected_q      <= 1'b0;
            err_underflow_q <= 1'b0;
        end else begin
            occupancy_q     <= occupancy_d;
            rejected_q      <= rejected_d;
            err_underflow_q <= err_underflow_d;
        end
    end

    assign occupancy     = occupancy_q;
    assign rejected      = rejected_q;
    assign err_underflow = err_underflow_q;
    assign vazio         = (occupancy_q == '0);
    assign cheio         = (occupancy_q == CNT_W'(CAPACITY));
    assign ent_allowed   = {N_GATES{!cheio && !lockout}};

endmodule

// File: tb/tb_parking_occupancy_ctrl.sv
// Bench for parking_occupancy_ctrl (2 gates, capacity 4, debounce 2); honours WATER_LOCKOUT_EN.
module tb_parking_occupancy_ctrl;

    localparam int N_GATES  = 2;
    localparam int CAPACITY = 4;
    localparam int DEBOUNCE = 2;
    localparam int CNT_W    = $clog2(CAPACITY + 1);

    logic               clk;
    logic               reset;
    logic [N_GATES-1:0] ent_sensor;
    logic [N_GATES-1:0] sai_sensor;
    logic               flood;
    logic [CNT_W-1:0]   occupancy;
    logic               vazio;
    logic               cheio;
    logic [N_GATES-1:0] ent_allowed;
    logic               rejected;
    logic               err_underflow;
    logic [4*N_GATES-1:0] det_state_dbg;

    int checks = 0;
    int errors = 0;

    parking_occupancy_ctrl #(
        .N_GATES  (N_GATES),
        .CAPACITY (CAPACITY),
        .DEBOUNCE (DEBOUNCE)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ent_sensor    (ent_sensor),
        .sai_sensor    (sai_sensor),
        .flood         (flood),
        .occupancy     (occupancy),
        .vazio         (vazio),
        .cheio         (cheio),
        .ent_allowed   (ent_allowed),
        .rejected      (rejected),
        .err_underflow (err_underflow),
        .det_state_dbg (det_state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a car is one run of DEBOUNCE consecutive high samples on a sensor
    // that has been seen low since reset; counting happens on the following edge.
    int   m_run [4];
    bit   m_armed [4];
    int   pend_ent, pend_exit;
    int   exp_occ;
    bit   exp_rej, exp_under;
    int   m_free, m_allow;
    bit   m_lock;
    logic [3:0] m_sens;

    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                m_run[i]   = 0;
                m_armed[i] = 1'b0;
            end
            pend_ent  = 0;
            pend_exit = 0;
            exp_occ   = 0;
            exp_rej   = 1'b0;
            exp_under = 1'b0;
        end else begin
`ifdef WATER_LOCKOUT_EN
            m_lock = flood;
`else
            m_lock = 1'b0;
`endif
            exp_under = (pend_exit > exp_occ);
            exp_occ   = exp_under ? 0 : exp_occ - pend_exit;
            m_free    = CAPACITY - exp_occ;
            m_allow   = m_lock ? 0 : ((pend_ent < m_free) ? pend_ent : m_free);
            exp_rej   = (pend_ent > m_allow);
            exp_occ   = exp_occ + m_allow;
            pend_ent  = 0;
            pend_exit = 0;
            m_sens    = {sai_sensor, ent_sensor};
            for (int i = 0; i < 4; i++) begin
                if (!m_armed[i]) begin
                    if (!m_sens[i]) m_armed[i] = 1'b1;
                end else begin
                    m_run[i] = m_sens[i] ? m_run[i] + 1 : 0;
                    if (m_sens[i] && m_run[i] == DEBOUNCE) begin
                        if (i < 2) pend_ent++;
                        else       pend_exit++;
                    end
                end
            end
        end
    end

    function automatic logic [N_GATES-1:0] exp_allowed(input int occ, input logic fl);
        logic open;
        open = (occ != CAPACITY);
`ifdef WATER_LOCKOUT_EN
        open = open && !fl;
`else
        if (fl) open = open;
`endif
        return {N_GATES{open}};
    endfunction

    // Driver: apply sensor levels for one clock, return 1 time unit after the edge.
    task automatic cycle(input logic [1:0] ent, input logic [1:0] sai);
        @(negedge clk);
        ent_sensor = ent;
        sai_sensor = sai;
        @(posedge clk);
        #1;
    endtask

    // One car per asserted bit: DEBOUNCE high samples, then low on the counting edge.
    task automatic pulse(input logic [1:0] ent, input logic [1:0] sai);
        cycle(ent, sai);
        cycle(ent, sai);
        cycle(2'b00, 2'b00);
    endtask

    task automatic do_reset(input logic [1:0] ent_hold);
        @(negedge clk);
        reset      = 1'b0;
        ent_sensor = ent_hold;
        sai_sensor = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(2'b00);
        checks++;
        if (occupancy !== 3'd0 || vazio !== 1'b1 || cheio !== 1'b0 || ent_allowed !== 2'b11 ||
            rejected !== 1'b0 || err_underflow !== 1'b0) begin
            errors++;
            $display("FAIL reset: occ=%0d vazio=%b cheio=%b allowed=%b rej=%b und=%b, want 0 1 0 11 0 0",
                     occupancy, vazio, cheio, ent_allowed, rejected, err_underflow);
        end
        cycle(2'b00, 2'b00);
    endtask

    task automatic test_entry_latency();
        logic [2:0] want [3];
        want[0] = 3'd0; want[1] = 3'd0; want[2] = 3'd1;
        for (int k = 0; k < 3; k++) begin
            cycle(2'b01, 2'b00);
            checks++;
            if (occupancy !== want[k]) begin
                errors++;
                $display("FAIL entry_latency edge%0d: occ=%0d want %0d", k + 1, occupancy, want[k]);
            end
        end
        cycle(2'b00, 2'b00);
        cycle(2'b01, 2'b00);
        cycle(2'b00, 2'b00);
        cycle(2'b00, 2'b00);
        checks++;
        if (occupancy !== 3'd1 || rejected !== 1'b0) begin
            errors++;
            $display("FAIL glitch: occ=%0d rej=%b want 1 0", occupancy, rejected);
        end
    endtask

    task automatic test_fill();
        for (int k = 2; k <= 4; k++) begin
            pulse(2'b01, 2'b00);
            checks++;
            if (occupancy !== 3'(k) || rejected !== 1'b0) begin
                errors++;
                $display("FAIL fill step: occ=%0d rej=%b want %0d 0", occupancy, rejected, k);
            end
        end
        checks++;
        if (cheio !== 1'b1 || vazio !== 1'b0 || ent_allowed !== 2'b00) begin
            errors++;
            $display("FAIL full_flags: cheio=%b vazio=%b allowed=%b want 1 0 00", cheio, vazio, ent_allowed);
        end
        pulse(2'b01, 2'b00);
        checks++;
        if (occupancy !== 3'd4 || rejected !== 1'b1) begin
            errors++;
            $display("FAIL fifth_entry: occ=%0d rej=%b want 4 1", occupancy, rejected);
        end
        cycle(2'b00, 2'b00);
        checks++;
        if (rejected !== 1'b0) begin
            errors++;
            $display("FAIL rej_pulse_width: rej=%b want 0", rejected);
        end
    endtask

    task automatic test_simultaneous();
        pulse(2'b00, 2'b01);
        checks++;
        if (occupancy !== 3'd3 || cheio !== 1'b0 || ent_allowed !== 2'b11) begin
            errors++;
            $display("FAIL exit_to_3: occ=%0d cheio=%b allowed=%b want 3 0 11", occupancy, cheio, ent_allowed);
        end
        pulse(2'b11, 2'b00);
        checks++;
        if (occupancy !== 3'd4 || rejected !== 1'b1) begin
            errors++;
            $display("FAIL two_entries_one_space: occ=%0d rej=%b want 4 1", occupancy, rejected);
        end
        pulse(2'b10, 2'b01);
        checks++;
        if (occupancy !== 3'd4 || rejected !== 1'b0 || err_underflow !== 1'b0) begin
            errors++;
            $display("FAIL exit_plus_entry_full: occ=%0d rej=%b und=%b want 4 0 0", occupancy, rejected, err_underflow);
        end
    endtask

    task automatic test_underflow();
        pulse(2'b00, 2'b11);
        pulse(2'b00, 2'b11);
        checks++;
        if (occupancy !== 3'd0 || vazio !== 1'b1 || err_underflow !== 1'b0) begin
            errors++;
            $display("FAIL drain: occ=%0d vazio=%b und=%b want 0 1 0", occupancy, vazio, err_underflow);
        end
        pulse(2'b00, 2'b01);
        checks++;
        if (occupancy !== 3'd0 || err_underflow !== 1'b1) begin
            errors++;
            $display("FAIL underflow: occ=%0d und=%b want 0 1", occupancy, err_underflow);
        end
        cycle(2'b00, 2'b00);
        checks++;
        if (err_underflow !== 1'b0) begin
            errors++;
            $display("FAIL und_pulse_width: und=%b want 0", err_underflow);
        end
    endtask

    task automatic test_held_through_reset();
        do_reset(2'b01);
        for (int k = 0; k < 4; k++) cycle(2'b01, 2'b00);
        checks++;
        if (occupancy !== 3'd0) begin
            errors++;
            $display("FAIL held_through_reset: occ=%0d want 0", occupancy);
        end
        cycle(2'b00, 2'b00);
        pulse(2'b01, 2'b00);
        checks++;
        if (occupancy !== 3'd1) begin
            errors++;
            $display("FAIL after_release_low: occ=%0d want 1", occupancy);
        end
    endtask

    task automatic test_flood();
        logic [2:0] want_occ;
        @(negedge clk);
        flood = 1'b1;
        #1;
        checks++;
`ifdef WATER_LOCKOUT_EN
        if (ent_allowed !== 2'b00) begin
`else
        if (ent_allowed !== 2'b11) begin
`endif
            errors++;
            $display("FAIL flood_allowed: allowed=%b", ent_allowed);
        end
        pulse(2'b01, 2'b00);
`ifdef WATER_LOCKOUT_EN
        want_occ = 3'd1;
        checks++;
        if (occupancy !== want_occ || rejected !== 1'b1) begin
`else
        want_occ = 3'd2;
        checks++;
        if (occupancy !== want_occ || rejected !== 1'b0) begin
`endif
            errors++;
            $display("FAIL flood_entry: occ=%0d rej=%b want occ %0d", occupancy, rejected, want_occ);
        end
        pulse(2'b00, 2'b01);
        checks++;
        if (occupancy !== want_occ - 3'd1) begin
            errors++;
            $display("FAIL flood_exit: occ=%0d want %0d", occupancy, want_occ - 3'd1);
        end
        @(negedge clk);
        flood = 1'b0;
    endtask

    task automatic test_random();
        do_reset(2'($urandom_range(0, 3)));
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 2) == 0) ent_sensor = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) sai_sensor = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) flood = ~flood;
            @(posedge clk);
            #1;
            checks++;
            if (occupancy !== 3'(exp_occ) || rejected !== exp_rej || err_underflow !== exp_under ||
                vazio !== (exp_occ == 0) || cheio !== (exp_occ == CAPACITY) ||
                ent_allowed !== exp_allowed(exp_occ, flood)) begin
                errors++;
                $display("FAIL random cyc%0d: occ=%0d rej=%b und=%b vazio=%b cheio=%b allowed=%b want occ=%0d rej=%b und=%b",
                         k, occupancy, rejected, err_underflow, vazio, cheio, ent_allowed,
                         exp_occ, exp_rej, exp_under);
            end
        end
        @(negedge clk);
        flood = 1'b0;
    endtask

    initial begin
        reset      = 1'b0;
        ent_sensor = '0;
        sai_sensor = '0;
        flood      = 1'b0;
        test_reset();
        test_entry_latency();
        test_fill();
        test_simultaneous();
        test_underflow();
        test_held_through_reset();
        test_flood();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
